// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: state encoding, opcodes, select/function codes
// and the control output bundle driven into ALU_System.
package control_unit_pkg;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_FETCH_L = 3'd1,
        S_FETCH_H = 3'd2,
        S_DECODE  = 3'd3,
        S_EXEC1   = 3'd4,
        S_EXEC2   = 3'd5,
        S_HALT    = 3'd7
    } state_t;

    localparam logic [3:0] OPC_LD  = 4'h0;
    localparam logic [3:0] OPC_ST  = 4'h1;
    localparam logic [3:0] OPC_LDI = 4'h2;
    localparam logic [3:0] OPC_ALU = 4'h3;
    localparam logic [3:0] OPC_BRA = 4'h4;
    localparam logic [3:0] OPC_BEQ = 4'h5;
    localparam logic [3:0] OPC_INC = 4'h6;
    localparam logic [3:0] OPC_DEC = 4'h7;
    localparam logic [3:0] OPC_HLT = 4'hF;

    localparam logic [1:0] FUN_CLR  = 2'b00;
    localparam logic [1:0] FUN_LOAD = 2'b01;
    localparam logic [1:0] FUN_DEC  = 2'b10;
    localparam logic [1:0] FUN_INC  = 2'b11;

    localparam logic [1:0] ARF_SEL_AR = 2'd0;
    localparam logic [1:0] ARF_SEL_PC = 2'd3;

    localparam logic [1:0] MUXA_ALU = 2'd0;
    localparam logic [1:0] MUXA_MEM = 2'd1;
    localparam logic [1:0] MUXA_IMM = 2'd2;
    localparam logic [1:0] MUXB_IMM = 2'd2;

    localparam logic [3:0] EN_ALL = 4'hF;
    localparam logic [3:0] EN_PC  = 4'b1000;
    localparam logic [3:0] EN_AR  = 4'b0100;

    typedef struct packed {
        logic [2:0] rf_out_a_sel;
        logic [2:0] rf_out_b_sel;
        logic [1:0] rf_fun_sel;
        logic [1:0] arf_fun_sel;
        logic [1:0] ir_funsel;
        logic [3:0] rf_r_sel;
        logic [3:0] rf_t_sel;
        logic [3:0] arf_reg_sel;
        logic [1:0] arf_out_c_sel;
        logic [1:0] arf_out_d_sel;
        logic [3:0] alu_fun_sel;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
        logic       ir_lh;
        logic       ir_enable;
        logic       mem_cs;
        logic       mem_wr;
    } ctrl_t;

    // Register index 0..3 names R1..R4; R1 sits in the MSB of the one-hot enable.
    function automatic logic [3:0] reg_en(input logic [1:0] idx);
        return 4'b1000 >> idx;
    endfunction

    function automatic logic [2:0] out_sel(input logic [1:0] idx);
        return {1'b1, idx};
    endfunction

    function automatic logic opc_defined(input logic [3:0] opc);
        return (opc <= OPC_DEC) || (opc == OPC_HLT);
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational output decoder: (state, latched opcode, instruction fields, Z) -> control bundle.
// While active is low (reset held) every output sits at its idle default.
module control_unit_decode
    import control_unit_pkg::*;
(
    input  state_t     state,
    input  logic       active,
    input  logic [3:0] opc,
    input  logic [1:0] rd,
    input  logic [1:0] rs,
    input  logic [3:0] alu_fn,
    input  logic       z,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.mem_cs = 1'b1;
        if (active) begin
            case (state)
                S_INIT: begin
                    ctrl.rf_r_sel    = EN_ALL;
                    ctrl.rf_t_sel    = EN_ALL;
                    ctrl.arf_reg_sel = EN_ALL;
                    ctrl.rf_fun_sel  = FUN_CLR;
                    ctrl.arf_fun_sel = FUN_CLR;
                    ctrl.ir_enable   = 1'b1;
                    ctrl.ir_funsel   = FUN_CLR;
                end
                // Both fetch halves read M[PC] and bump PC on the same edge.
                S_FETCH_L, S_FETCH_H: begin
                    ctrl.arf_out_d_sel = ARF_SEL_PC;
                    ctrl.mem_cs        = 1'b0;
                    ctrl.ir_enable     = 1'b1;
                    ctrl.ir_funsel     = FUN_LOAD;
                    ctrl.ir_lh         = (state == S_FETCH_H);
                    ctrl.arf_reg_sel   = EN_PC;
                    ctrl.arf_fun_sel   = FUN_INC;
                end
                S_EXEC1: begin
                    case (opc)
                        OPC_LD, OPC_ST: begin
                            ctrl.mux_b_sel   = MUXB_IMM;
                            ctrl.arf_fun_sel = FUN_LOAD;
                            ctrl.arf_reg_sel = EN_AR;
                        end
                        OPC_LDI: begin
                            ctrl.mux_a_sel  = MUXA_IMM;
                            ctrl.rf_fun_sel = FUN_LOAD;
                            ctrl.rf_r_sel   = reg_en(rd);
                        end
                        OPC_ALU: begin
                            ctrl.rf_out_a_sel = out_sel(rd);
                            ctrl.rf_out_b_sel = out_sel(rs);
                            ctrl.alu_fun_sel  = alu_fn;
                            ctrl.mux_a_sel    = MUXA_ALU;
                            ctrl.rf_fun_sel   = FUN_LOAD;
                            ctrl.rf_r_sel     = reg_en(rd);
                        end
                        OPC_BRA, OPC_BEQ: begin
                            ctrl.mux_b_sel   = MUXB_IMM;
                            ctrl.arf_fun_sel = FUN_LOAD;
                            ctrl.arf_reg_sel = (opc == OPC_BRA || z) ? EN_PC : 4'b0000;
                        end
                        OPC_INC, OPC_DEC: begin
                            ctrl.rf_fun_sel = (opc == OPC_INC) ? FUN_INC : FUN_DEC;
                            ctrl.rf_r_sel   = reg_en(rd);
                        end
                        default: ;
                    endcase
                end
                S_EXEC2: begin
                    if (opc == OPC_LD) begin
                        ctrl.arf_out_d_sel = ARF_SEL_AR;
                        ctrl.mem_cs        = 1'b0;
                        ctrl.mux_a_sel     = MUXA_MEM;
                        ctrl.rf_fun_sel    = FUN_LOAD;
                        ctrl.rf_r_sel      = reg_en(rd);
                    end else if (opc == OPC_ST) begin
                        ctrl.rf_out_a_sel  = out_sel(rd);
                        ctrl.alu_fun_sel   = 4'h0;
                        ctrl.arf_out_d_sel = ARF_SEL_AR;
                        ctrl.mem_cs        = 1'b0;
                        ctrl.mem_wr        = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for ALU_System. Holds state, latched opcode and
// the Z flag captured from the last ALU instruction; outputs come from control_unit_decode.
module control_unit
    import control_unit_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0,
    parameter int ZFLAG_BIT       = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ir_out,
    input  logic [3:0]  alu_out_flag,
    output logic [2:0]  rf_out_a_sel,
    output logic [2:0]  rf_out_b_sel,
    output logic [1:0]  rf_fun_sel,
    output logic [1:0]  arf_fun_sel,
    output logic [1:0]  ir_funsel,
    output logic [3:0]  rf_r_sel,
    output logic [3:0]  rf_t_sel,
    output logic [3:0]  arf_reg_sel,
    output logic [1:0]  arf_out_c_sel,
    output logic [1:0]  arf_out_d_sel,
    output logic [3:0]  alu_fun_sel,
    output logic [1:0]  mux_a_sel,
    output logic [1:0]  mux_b_sel,
    output logic        mux_c_sel,
    output logic        ir_lh,
    output logic        ir_enable,
    output logic        mem_cs,
    output logic        mem_wr,
    output logic [2:0]  state,
    output logic        halted
);

    state_t     state_reg;
    logic [3:0] opc_reg;
    logic       z_reg;
    ctrl_t      ctrl;
    logic       fields_unused;

    // Immediate bits and non-Z flags are consumed by the datapath, not here.
    assign fields_unused = ^{ir_out[7:4], alu_out_flag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_INIT;
            opc_reg   <= 4'h0;
            z_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_INIT:    state_reg <= S_FETCH_L;
                S_FETCH_L: state_reg <= S_FETCH_H;
                S_FETCH_H: state_reg <= S_DECODE;
                S_DECODE: begin
                    opc_reg <= ir_out[15:12];
                    if (ir_out[15:12] == OPC_HLT ||
                        (HALT_ON_ILLEGAL && !opc_defined(ir_out[15:12])))
                        state_reg <= S_HALT;
                    else
                        state_reg <= S_EXEC1;
                end
                S_EXEC1: begin
                    if (opc_reg == OPC_ALU)
                        z_reg <= alu_out_flag[ZFLAG_BIT];
                    state_reg <= (opc_reg == OPC_LD || opc_reg == OPC_ST) ? S_EXEC2 : S_FETCH_L;
                end
                S_EXEC2:   state_reg <= S_FETCH_L;
                S_HALT:    state_reg <= S_HALT;
                default:   state_reg <= S_INIT;
            endcase
        end
    end

    control_unit_decode u_decode (
        .state  (state_reg),
        .active (rst_n),
        .opc    (opc_reg),
        .rd     (ir_out[11:10]),
        .rs     (ir_out[9:8]),
        .alu_fn (ir_out[3:0]),
        .z      (z_reg),
        .ctrl   (ctrl)
    );

    assign rf_out_a_sel  = ctrl.rf_out_a_sel;
    assign rf_out_b_sel  = ctrl.rf_out_b_sel;
    assign rf_fun_sel    = ctrl.rf_fun_sel;
    assign arf_fun_sel   = ctrl.arf_fun_sel;
    assign ir_funsel     = ctrl.ir_funsel;
    assign rf_r_sel      = ctrl.rf_r_sel;
    assign rf_t_sel      = ctrl.rf_t_sel;
    assign arf_reg_sel   = ctrl.arf_reg_sel;
    assign arf_out_c_sel = ctrl.arf_out_c_sel;
    assign arf_out_d_sel = ctrl.arf_out_d_sel;
    assign alu_fun_sel   = ctrl.alu_fun_sel;
    assign mux_a_sel     = ctrl.mux_a_sel;
    assign mux_b_sel     = ctrl.mux_b_sel;
    assign mux_c_sel     = ctrl.mux_c_sel;
    assign ir_lh         = ctrl.ir_lh;
    assign ir_enable     = ctrl.ir_enable;
    assign mem_cs        = ctrl.mem_cs;
    assign mem_wr        = ctrl.mem_wr;
    assign state         = state_reg;
    assign halted        = (state_reg == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a small ALU_System/memory model is steered by the DUT; expected
// architectural state at each DECODE and each memory write is queued and checked by a monitor.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ir_out;
    logic [3:0]  alu_out_flag;
    logic [2:0]  rf_out_a_sel, rf_out_b_sel, state;
    logic [1:0]  rf_fun_sel, arf_fun_sel, ir_funsel, arf_out_c_sel, arf_out_d_sel;
    logic [3:0]  rf_r_sel, rf_t_sel, arf_reg_sel, alu_fun_sel;
    logic [1:0]  mux_a_sel, mux_b_sel;
    logic        mux_c_sel, ir_lh, ir_enable, mem_cs, mem_wr, halted;

    always #5 clk = ~clk;

    control_unit #(.HALT_ON_ILLEGAL(1'b0), .ZFLAG_BIT(3)) dut (
        .clk(clk), .rst_n(rst_n), .ir_out(ir_out), .alu_out_flag(alu_out_flag),
        .rf_out_a_sel(rf_out_a_sel), .rf_out_b_sel(rf_out_b_sel),
        .rf_fun_sel(rf_fun_sel), .arf_fun_sel(arf_fun_sel), .ir_funsel(ir_funsel),
        .rf_r_sel(rf_r_sel), .rf_t_sel(rf_t_sel), .arf_reg_sel(arf_reg_sel),
        .arf_out_c_sel(arf_out_c_sel), .arf_out_d_sel(arf_out_d_sel),
        .alu_fun_sel(alu_fun_sel), .mux_a_sel(mux_a_sel), .mux_b_sel(mux_b_sel),
        .mux_c_sel(mux_c_sel), .ir_lh(ir_lh), .ir_enable(ir_enable),
        .mem_cs(mem_cs), .mem_wr(mem_wr), .state(state), .halted(halted)
    );

    // ---------------- datapath + memory model ----------------
    logic [7:0]  mem [256];
    logic [7:0]  rf [4];
    logic [7:0]  tr [4];
    logic [7:0]  pc, ar, sp, pcp;
    logic [15:0] ir;
    logic [7:0]  op_a, op_b, alu_res, mem_addr, mem_rdata, arf_c, mux_a_out, mux_b_out, mux_c_out;

    assign ir_out = ir;

    function automatic logic [7:0] apply_fun(input logic [1:0] f, input logic [7:0] q, input logic [7:0] d);
        case (f)
            2'b00:   return 8'h00;
            2'b01:   return d;
            2'b10:   return q - 8'd1;
            default: return q + 8'd1;
        endcase
    endfunction

    always_comb begin
        op_a = rf_out_a_sel[2] ? rf[rf_out_a_sel[1:0]] : tr[rf_out_a_sel[1:0]];
        op_b = rf_out_b_sel[2] ? rf[rf_out_b_sel[1:0]] : tr[rf_out_b_sel[1:0]];
        case (alu_fun_sel)
            4'h0:    alu_res = op_a;
            4'h1:    alu_res = op_b;
            4'h4:    alu_res = op_a + op_b;
            4'h6:    alu_res = op_a - op_b;
            default: alu_res = op_a;
        endcase
        alu_out_flag = {alu_res == 8'h00, 1'b0, alu_res[7], 1'b0};
        case (arf_out_d_sel)
            2'd0:    mem_addr = ar;
            2'd1:    mem_addr = sp;
            2'd2:    mem_addr = pcp;
            default: mem_addr = pc;
        endcase
        case (arf_out_c_sel)
            2'd0:    arf_c = ar;
            2'd1:    arf_c = sp;
            2'd2:    arf_c = pcp;
            default: arf_c = pc;
        endcase
        mem_rdata = mem[mem_addr];
        case (mux_a_sel)
            2'd0:    mux_a_out = alu_res;
            2'd1:    mux_a_out = mem_rdata;
            2'd2:    mux_a_out = ir[7:0];
            default: mux_a_out = arf_c;
        endcase
        case (mux_b_sel)
            2'd0:    mux_b_out = alu_res;
            2'd1:    mux_b_out = mem_rdata;
            2'd2:    mux_b_out = ir[7:0];
            default: mux_b_out = arf_c;
        endcase
        mux_c_out = mux_c_sel ? arf_c : alu_res;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rf_r_sel[3-i]) rf[i] <= apply_fun(rf_fun_sel, rf[i], mux_a_out);
            if (rf_t_sel[3-i]) tr[i] <= apply_fun(rf_fun_sel, tr[i], mux_a_out);
        end
        if (arf_reg_sel[3]) pc  <= apply_fun(arf_fun_sel, pc, mux_b_out);
        if (arf_reg_sel[2]) ar  <= apply_fun(arf_fun_sel, ar, mux_b_out);
        if (arf_reg_sel[1]) sp  <= apply_fun(arf_fun_sel, sp, mux_b_out);
        if (arf_reg_sel[0]) pcp <= apply_fun(arf_fun_sel, pcp, mux_b_out);
        if (ir_enable) begin
            if (ir_funsel == 2'b00) ir <= 16'h0000;
            else if (ir_funsel == 2'b01) begin
                if (ir_lh) ir[15:8] <= mem_rdata;
                else       ir[7:0]  <= mem_rdata;
            end
        end
        if (!mem_cs && mem_wr) mem[mem_addr] <= mux_c_out;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0]  pc, r1, r2, r3, r4;
        logic [15:0] ir;
        logic [7:0]  dt;
    } dec_exp_t;

    typedef struct packed {
        logic [7:0] addr, data;
    } wr_exp_t;

    dec_exp_t dec_q[$];
    wr_exp_t  wr_q[$];
    int checks = 0, errors = 0;
    int cyc = 0, last_dec = 0, txn = 0, wr_cycles = 0, viol = 0;

    localparam logic [40:0] DEFAULT_VEC = 41'd2;
    logic [40:0] ctrl_vec;
    assign ctrl_vec = {rf_out_a_sel, rf_out_b_sel, rf_fun_sel, arf_fun_sel, ir_funsel,
                       rf_r_sel, rf_t_sel, arf_reg_sel, arf_out_c_sel, arf_out_d_sel,
                       alu_fun_sel, mux_a_sel, mux_b_sel, mux_c_sel, ir_lh, ir_enable,
                       mem_cs, mem_wr};

    task automatic chk(input string name, input logic [40:0] act, input logic [40:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_dec(input logic [7:0] epc, input logic [7:0] r1, input logic [7:0] r2,
                            input logic [7:0] r3, input logic [7:0] r4, input logic [15:0] eir,
                            input logic [7:0] dt);
        dec_q.push_back({epc, r1, r2, r3, r4, eir, dt});
    endtask

    always @(negedge clk) begin
        dec_exp_t e;
        wr_exp_t  w;
        int       nld;
        cyc++;
        if (rst_n) begin
            nld = 0;
            if (rf_fun_sel == 2'b01 && rf_r_sel != 4'h0 && mux_a_sel == 2'd1) nld++;
            if (arf_fun_sel == 2'b01 && arf_reg_sel != 4'h0 && mux_b_sel == 2'd1) nld++;
            if (ir_enable && ir_funsel == 2'b01) nld++;
            if (nld > 1 || (mem_wr && mem_cs)) viol++;
            if (state == 3'd3) begin
                txn++;
                if (dec_q.size() == 0) chk($sformatf("dec%0d_unexpected", txn), 41'd1, 41'd0);
                else begin
                    e = dec_q.pop_front();
                    $display("txn %0d: decode ir=%h pc=%h r1=%h r2=%h r3=%h r4=%h dt=%0d",
                             txn, ir, pc, rf[0], rf[1], rf[2], rf[3], cyc - last_dec);
                    chk($sformatf("dec%0d_ir", txn), 41'(ir), 41'(e.ir));
                    chk($sformatf("dec%0d_pc", txn), 41'(pc), 41'(e.pc));
                    chk($sformatf("dec%0d_regs", txn), 41'({rf[0], rf[1], rf[2], rf[3]}),
                        41'({e.r1, e.r2, e.r3, e.r4}));
                    if (e.dt != 8'd0)
                        chk($sformatf("dec%0d_latency", txn), 41'(cyc - last_dec), 41'(e.dt));
                end
                last_dec = cyc;
            end
            if (mem_wr) begin
                wr_cycles++;
                $display("txn write: addr=%h data=%h cs=%b", mem_addr, mux_c_out, mem_cs);
                if (wr_q.size() == 0) chk("wr_unexpected", 41'd1, 41'd0);
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 41'(mem_addr), 41'(w.addr));
                    chk("wr_data", 41'(mux_c_out), 41'(w.data));
                    chk("wr_cs", 41'(mem_cs), 41'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[8'h01], mem[8'h00]} = 16'h205A;  // LDI R1,0x5A
        {mem[8'h03], mem[8'h02]} = 16'h1080;  // ST  R1,0x80
        {mem[8'h05], mem[8'h04]} = 16'h0880;  // LD  R3,0x80
        {mem[8'h07], mem[8'h06]} = 16'h3506;  // SUB R2,R2
        {mem[8'h09], mem[8'h08]} = 16'h5040;  // BEQ 0x40 (taken)
        {mem[8'h41], mem[8'h40]} = 16'h6400;  // INC R2
        {mem[8'h43], mem[8'h42]} = 16'h3106;  // SUB R1,R2
        {mem[8'h45], mem[8'h44]} = 16'h5060;  // BEQ 0x60 (not taken)
        {mem[8'h47], mem[8'h46]} = 16'h7C00;  // DEC R4
        {mem[8'h49], mem[8'h48]} = 16'h8000;  // illegal -> NOP
        {mem[8'h4B], mem[8'h4A]} = 16'h40FE;  // BRA 0xFE
        {mem[8'hFF], mem[8'hFE]} = 16'hF000;  // HLT, PC wraps to 0x00

        push_dec(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 16'h205A, 8'd0);
        push_dec(8'h04, 8'h5A, 8'h00, 8'h00, 8'h00, 16'h1080, 8'd4);
        push_dec(8'h06, 8'h5A, 8'h00, 8'h00, 8'h00, 16'h0880, 8'd5);
        push_dec(8'h08, 8'h5A, 8'h00, 8'h5A, 8'h00, 16'h3506, 8'd5);
        push_dec(8'h0A, 8'h5A, 8'h00, 8'h5A, 8'h00, 16'h5040, 8'd4);
        push_dec(8'h42, 8'h5A, 8'h00, 8'h5A, 8'h00, 16'h6400, 8'd4);
        push_dec(8'h44, 8'h5A, 8'h01, 8'h5A, 8'h00, 16'h3106, 8'd4);
        push_dec(8'h46, 8'h59, 8'h01, 8'h5A, 8'h00, 16'h5060, 8'd4);
        push_dec(8'h48, 8'h59, 8'h01, 8'h5A, 8'h00, 16'h7C00, 8'd4);
        push_dec(8'h4A, 8'h59, 8'h01, 8'h5A, 8'hFF, 16'h8000, 8'd4);
        push_dec(8'h4C, 8'h59, 8'h01, 8'h5A, 8'hFF, 16'h40FE, 8'd4);
        push_dec(8'h00, 8'h59, 8'h01, 8'h5A, 8'hFF, 16'hF000, 8'd4);
        wr_q.push_back({8'h80, 8'h5A});

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 41'(state), 41'd0);
        chk("reset_halted", 41'(halted), 41'd0);
        chk("reset_outputs", ctrl_vec, DEFAULT_VEC);
        rst_n = 1'b1;

        for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
        chk("halt_reached", 41'(halted), 41'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("halt%0d_flag", i), 41'({halted, state}), 41'({1'b1, 3'd7}));
            chk($sformatf("halt%0d_outputs", i), ctrl_vec, DEFAULT_VEC);
        end
        chk("dec_q_drained", 41'(dec_q.size()), 41'd0);
        chk("wr_q_drained", 41'(wr_q.size()), 41'd0);
        chk("wr_one_cycle", 41'(wr_cycles), 41'd1);
        chk("mem80", 41'(mem[8'h80]), 41'h5A);

        // Reset abort during E2 of a store: memory must be untouched.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        {mem[8'h01], mem[8'h00]} = 16'h1490;  // ST R2,0x90
        mem[8'h90] = 8'hA5;
        push_dec(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 16'h1490, 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20 && state != 3'd4; i++) @(negedge clk);
        chk("st_exec1_reached", 41'(state), 41'd4);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_state", 41'({halted, state}), 41'd0);
        chk("abort_outputs", ctrl_vec, DEFAULT_VEC);
        @(negedge clk);
        chk("abort_mem90", 41'(mem[8'h90]), 41'hA5);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_fetch", 41'(state), 41'd1);
        chk("abort_mem90_after", 41'(mem[8'h90]), 41'hA5);
        chk("viol_free", 41'(viol), 41'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
